// File: rtl/sysbus_arb_if.sv
// Signal bundle between the system-bus arbiter and its requesters / bus side.
// The arbiter connects through the slave modport; the requester side uses master.
interface sysbus_arb_if;
  logic [0:3] req;
  logic [0:3] hold;
  logic       zw;
  logic       ren;
  logic       rok;
  logic       rpe;
  logic       zg;
  logic [0:3] gnt;
  logic       done;
  logic       perr;
  logic       talarm;
  logic       busy;

  modport slave (
    input  req, hold, zw, ren, rok, rpe,
    output zg, gnt, done, perr, talarm, busy
  );

  modport master (
    output req, hold, zw, ren, rok, rpe,
    input  zg, gnt, done, perr, talarm, busy
  );
endinterface

// File: rtl/sysbus_arb.sv
// Four-requester system-bus arbiter with reply timeout and bus hold.
// Define SYSBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index) instead of round-robin.
module sysbus_arb #(
  parameter int unsigned ALARM_TICKS = 16'd500,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk_sys,
  input  logic        hltn_reset,
  sysbus_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_TICKS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       owner;
  logic [1:0]       owner_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             zg_q;
  logic             zg_nxt;
  logic [0:3]       gnt_q;
  logic [0:3]       gnt_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             perr_q;
  logic             perr_nxt;
  logic             talarm_q;
  logic             talarm_nxt;
  logic             busy;

  logic oken;
  logic expire;
  logic keep;

  // First requester at or above base, wrapping 3 -> 0.
  function automatic logic [1:0] pick(input logic [0:3] r, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign oken   = bus.ren | bus.rok;
  assign expire = (cnt == CNT_LAST);
  assign keep   = bus.hold[owner] & bus.req[owner];

  always_ff @(posedge clk_sys or negedge hltn_reset) begin
    if (!hltn_reset) begin
      state    <= ST_IDLE;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      cnt      <= '0;
      zg_q     <= 1'b0;
      gnt_q    <= '0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      talarm_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      zg_q     <= zg_nxt;
      gnt_q    <= gnt_nxt;
      done_q   <= done_nxt;
      perr_q   <= perr_nxt;
      talarm_q <= talarm_nxt;
    end
  end

  // A grant in REQ takes precedence over a same-cycle request withdrawal.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|bus.req) state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.zw)                 state_nxt = ST_XFER;
        else if (!bus.req[owner])   state_nxt = ST_IDLE;
      end
      ST_XFER: begin
        if (oken)        state_nxt = ST_RESP;
        else if (expire) state_nxt = ST_IDLE;
      end
      ST_RESP: if (!oken) state_nxt = keep ? ST_XFER : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_nxt  = owner;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    zg_nxt     = zg_q;
    gnt_nxt    = gnt_q;
    done_nxt   = 1'b0;
    perr_nxt   = 1'b0;
    talarm_nxt = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          owner_nxt = pick(bus.req, ptr);
          zg_nxt    = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.zw) begin
          gnt_nxt        = '0;
          gnt_nxt[owner] = 1'b1;
          cnt_nxt        = '0;
        end else if (!bus.req[owner]) begin
          zg_nxt = 1'b0;
        end
      end
      ST_XFER: begin
        if (oken) begin
          done_nxt = 1'b1;
          perr_nxt = bus.rpe;
        end else if (expire) begin
          talarm_nxt = 1'b1;
          gnt_nxt    = '0;
          zg_nxt     = 1'b0;
          ptr_nxt    = owner + 2'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (!oken) begin
          if (keep) begin
            cnt_nxt = '0;
          end else begin
            gnt_nxt = '0;
            zg_nxt  = 1'b0;
            ptr_nxt = owner + 2'd1;
          end
        end
      end
      default: begin
        gnt_nxt = '0;
        zg_nxt  = 1'b0;
      end
    endcase
`ifdef SYSBUS_ARB_FIXED_PRIO_EN
    ptr_nxt = 2'd0;
`else
    ptr_nxt = ptr_nxt;
`endif
  end

  assign bus.zg     = zg_q;
  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.perr   = perr_q;
  assign bus.talarm = talarm_q;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_sysbus_arb.sv
// Directed bench for sysbus_arb with ALARM_TICKS=8; inputs driven and outputs sampled on falling edges.
module tb_sysbus_arb;
  logic clk_sys = 1'b0;
  logic hltn_reset;
  int   n_pass = 0;
  int   n_tot  = 0;

  sysbus_arb_if bus();

  sysbus_arb #(.ALARM_TICKS(8), .CNT_W(16)) dut (
    .clk_sys    (clk_sys),
    .hltn_reset (hltn_reset),
    .bus        (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [0:3] onehot(input int who);
    logic [0:3] v;
    v = '0;
    v[who] = 1'b1;
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_zg"},     32'(bus.zg),     32'd0);
    chk({tag, "_gnt"},    32'(bus.gnt),    32'd0);
    chk({tag, "_done"},   32'(bus.done),   32'd0);
    chk({tag, "_perr"},   32'(bus.perr),   32'd0);
    chk({tag, "_talarm"}, 32'(bus.talarm), 32'd0);
    chk({tag, "_busy"},   32'(bus.busy),   32'd0);
  endtask

  // Called at an IDLE falling edge with req and zw already driven.
  task automatic xfer(input string tag, input int who);
    nclk(2);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(onehot(who)));
    chk({tag, "_zg"},  32'(bus.zg),  32'd1);
    bus.rok = 1'b1;
    nclk(1);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    bus.rok = 1'b0;
    nclk(1);
    chk({tag, "_end_gnt"},  32'(bus.gnt),  32'd0);
    chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int exp_owner;
    hltn_reset = 1'b0;
    bus.req  = '0;
    bus.hold = '0;
    bus.zw   = 1'b0;
    bus.ren  = 1'b0;
    bus.rok  = 1'b0;
    bus.rpe  = 1'b0;
    nclk(2);
    chk_idle("reset");
    hltn_reset = 1'b1;

    // Single transfer for requester 2 with delayed zw and rok.
    bus.req[2] = 1'b1;
    nclk(1);
    chk("t1_zg_c1",   32'(bus.zg),   32'd1);
    chk("t1_busy_c1", 32'(bus.busy), 32'd1);
    chk("t1_gnt_c1",  32'(bus.gnt),  32'd0);
    nclk(1);
    chk("t1_gnt_c2", 32'(bus.gnt), 32'd0);
    bus.zw = 1'b1;
    nclk(1);
    chk("t1_gnt", 32'(bus.gnt), 32'(onehot(2)));
    bus.zw = 1'b0;
    nclk(2);
    chk("t1_nodone", 32'(bus.done), 32'd0);
    bus.rok = 1'b1;
    nclk(1);
    chk("t1_done",     32'(bus.done), 32'd1);
    chk("t1_perr",     32'(bus.perr), 32'd0);
    chk("t1_gnt_resp", 32'(bus.gnt),  32'(onehot(2)));
    bus.rok    = 1'b0;
    bus.req[2] = 1'b0;
    nclk(1);
    chk_idle("t1_end");

    // Withdrawal before zw: no grant, pointer untouched.
    bus.req[1] = 1'b1;
    nclk(1);
    chk("wd_zg", 32'(bus.zg), 32'd1);
    bus.req[1] = 1'b0;
    nclk(1);
    chk_idle("wd_end");

    // Requesters 0 and 3: pointer 3 selects 3 (fixed priority selects 0).
`ifdef SYSBUS_ARB_FIXED_PRIO_EN
    exp_owner = 0;
`else
    exp_owner = 3;
`endif
    bus.req[0] = 1'b1;
    bus.req[3] = 1'b1;
    bus.zw     = 1'b1;
    xfer("ptr3", exp_owner);

    // All four requesting: rotation 0,1,2,3.
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
`ifdef SYSBUS_ARB_FIXED_PRIO_EN
      exp_owner = 0;
`else
      exp_owner = i;
`endif
      xfer($sformatf("rr%0d", i), exp_owner);
    end
    bus.req = '0;

    // Timeout: talarm exactly 8 cycles after gnt rises.
    bus.req[1] = 1'b1;
    nclk(2);
    chk("to_gnt", 32'(bus.gnt), 32'(onehot(1)));
    for (int k = 1; k < 8; k++) begin
      nclk(1);
      chk($sformatf("to_quiet%0d", k), 32'({bus.talarm, bus.done}), 32'd0);
    end
    nclk(1);
    chk("to_talarm", 32'(bus.talarm), 32'd1);
    chk("to_gnt0",   32'(bus.gnt),    32'd0);
    chk("to_zg0",    32'(bus.zg),     32'd0);
    chk("to_done0",  32'(bus.done),   32'd0);
    bus.req = '0;
    nclk(1);
    chk_idle("to_end");

    // Hold: three back-to-back transfers without releasing the bus.
    bus.req[1]  = 1'b1;
    bus.hold[1] = 1'b1;
    nclk(2);
    chk("hold_gnt", 32'(bus.gnt), 32'(onehot(1)));
    for (int i = 0; i < 3; i++) begin
      bus.rok = 1'b1;
      nclk(1);
      chk($sformatf("hold_done%0d", i), 32'(bus.done), 32'd1);
      chk($sformatf("hold_gnt%0d", i),  32'({bus.zg, bus.gnt}), 32'({1'b1, onehot(1)}));
      bus.rok = 1'b0;
      if (i == 2) begin
        bus.hold = '0;
        bus.req  = '0;
      end
      nclk(1);
      chk($sformatf("hold_pulse%0d", i), 32'(bus.done), 32'd0);
      if (i < 2) chk($sformatf("hold_keep%0d", i), 32'({bus.zg, bus.gnt}), 32'({1'b1, onehot(1)}));
      else       chk_idle("hold_end");
    end

    // Reply with parity error on the expiry cycle wins over the timeout.
    bus.req[2] = 1'b1;
    nclk(2);
    chk("race_gnt", 32'(bus.gnt), 32'(onehot(2)));
    nclk(7);
    chk("race_pre", 32'(bus.talarm), 32'd0);
    bus.rok = 1'b1;
    bus.rpe = 1'b1;
    nclk(1);
    chk("race_done",   32'(bus.done),   32'd1);
    chk("race_perr",   32'(bus.perr),   32'd1);
    chk("race_talarm", 32'(bus.talarm), 32'd0);
    bus.rok = 1'b0;
    bus.rpe = 1'b0;
    bus.req = '0;
    nclk(1);
    chk("race_after_talarm", 32'(bus.talarm), 32'd0);
    chk("race_after_perr",   32'(bus.perr),   32'd0);
    nclk(1);
    chk_idle("race_end");

    // Asynchronous reset during a transfer, then arbitration from pointer 0.
    bus.req[0] = 1'b1;
    nclk(2);
    chk("rst_gnt", 32'(bus.gnt), 32'(onehot(0)));
    #2 hltn_reset = 1'b0;
    #1 chk_idle("rst_async");
    bus.req = '0;
    bus.zw  = 1'b0;
    nclk(2);
    hltn_reset = 1'b1;
    nclk(1);
    chk_idle("rst_after");
    bus.req[1] = 1'b1;
    bus.req[3] = 1'b1;
    bus.zw     = 1'b1;
    xfer("rst_ptr0", 1);
    bus.req = '0;
    bus.zw  = 1'b0;
    nclk(1);
    chk_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
